// File: rtl/pipeline_ctrl_pkg.sv
// Shared stage indices, hold/bubble encodings and FSM state codes for the pipeline controller.
// Also provides the stall-at-stage helper that turns a stalling stage into a hold/bubble pair.
package pipeline_ctrl_pkg;

  localparam int NSTG = 5;

  localparam logic STALL_NO  = 1'b0;
  localparam logic STALL_YES = 1'b1;

  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_MEMWB = 4;

  localparam logic [1:0] PC_RUN     = 2'd0;
  localparam logic [1:0] PC_MEMWAIT = 2'd1;
  localparam logic [1:0] PC_TOFLUSH = 2'd2;

  typedef struct packed {
    logic [NSTG-1:0] stall;
    logic [NSTG-1:0] bubble;
    logic            flush;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{stall: '0, bubble: '0, flush: 1'b0};

  // A stall at stage s freezes every register up to and including s and injects a NOP just after it.
  function automatic ctl_t stall_at(input int s);
    ctl_t c;
    c = CTL_IDLE;
    for (int i = 0; i < NSTG; i++) begin
      if (i <= s) begin
        c.stall[i] = STALL_YES;
      end else begin
        c.stall[i] = STALL_NO;
      end
      if (i == s + 1) begin
        c.bubble[i] = 1'b1;
      end
    end
    return c;
  endfunction

  function automatic ctl_t flush_ctl(input logic with_memwb);
    ctl_t c;
    c = CTL_IDLE;
    c.flush            = 1'b1;
    c.bubble[STG_IFID]  = 1'b1;
    c.bubble[STG_IDEX]  = 1'b1;
    c.bubble[STG_EXMEM] = 1'b1;
    c.bubble[STG_MEMWB] = with_memwb;
    return c;
  endfunction

  localparam ctl_t CTL_MEM     = stall_at(STG_EXMEM);
  localparam ctl_t CTL_EX      = stall_at(STG_IDEX);
  localparam ctl_t CTL_ID      = stall_at(STG_IFID);
  localparam ctl_t CTL_FLUSH   = flush_ctl(1'b0);
  localparam ctl_t CTL_TOFLUSH = flush_ctl(1'b1);

endpackage

// File: rtl/pipe_watchdog.sv
// MEM bus-wait watchdog: counts consecutive wait cycles, expire is combinational on the TIMEOUT-th cycle.
// The counter restarts at 1 on start, advances while busy, and clears otherwise.
module pipe_watchdog #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  output logic expire
);

  logic [CNT_W-1:0] r_wd_cnt;

  assign expire = busy && (r_wd_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt <= '0;
    end else if (start) begin
      r_wd_cnt <= CNT_W'(1);
    end else if (busy && !expire) begin
      r_wd_cnt <= r_wd_cnt + CNT_W'(1);
    end else begin
      r_wd_cnt <= '0;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5 pipeline registers; hold/bubble/flush are 0-cycle combinational.
// Requests are priority-merged, lower ones are masked until served; bus_timeout is a registered-state pulse.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NSTAGE  = 5,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              flush_req,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] bubble,
  output logic              flush,
  output logic              bus_timeout,
  output logic [PERF_W-1:0] stall_cnt
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_wd_start;
  logic              w_wd_busy;
  logic              w_wd_expire;
  ctl_t              w_ctl;
  logic [PERF_W-1:0] r_stall_cnt;

  assign w_wd_start = (r_state == PC_RUN) && stallreq_mem;
  assign w_wd_busy  = (r_state == PC_MEMWAIT) && stallreq_mem;

  pipe_watchdog #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .start  (w_wd_start),
    .busy   (w_wd_busy),
    .expire (w_wd_expire)
  );

  always_comb begin
    w_state_nxt = PC_RUN;
    case (r_state)
      PC_RUN:     w_state_nxt = stallreq_mem ? PC_MEMWAIT : PC_RUN;
      PC_MEMWAIT: begin
        if (!stallreq_mem) begin
          w_state_nxt = PC_RUN;
        end else if (w_wd_expire) begin
          w_state_nxt = PC_TOFLUSH;
        end else begin
          w_state_nxt = PC_MEMWAIT;
        end
      end
      default:    w_state_nxt = PC_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= PC_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs are forced idle while reset is asserted so downstream synchronous resets are not held off.
  always_comb begin
    w_ctl = CTL_IDLE;
    if (rst) begin
      if (r_state == PC_TOFLUSH) begin
        w_ctl = CTL_TOFLUSH;
      end else if (stallreq_mem) begin
        w_ctl = CTL_MEM;
      end else if (flush_req) begin
        w_ctl = CTL_FLUSH;
      end else if (stallreq_ex) begin
        w_ctl = CTL_EX;
      end else if (stallreq_id) begin
        w_ctl = CTL_ID;
      end
    end
  end

  assign stall       = w_ctl.stall;
  assign bubble      = w_ctl.bubble;
  assign flush       = w_ctl.flush;
  assign bus_timeout = (r_state == PC_TOFLUSH);
  assign stall_cnt   = r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if ((|w_ctl.stall) && (r_stall_cnt != {PERF_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized + directed bench for pipeline_ctrl against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int TO   = 4;
  localparam int PW   = 4;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk;
  logic          rst;
  logic          stallreq_id;
  logic          stallreq_ex;
  logic          stallreq_mem;
  logic          flush_req;
  logic [4:0]    stall;
  logic [4:0]    bubble;
  logic          flush;
  logic          bus_timeout;
  logic [PW-1:0] stall_cnt;

  int n_total = 0;
  int n_bad   = 0;

  // model state: length of the current MEM wait, pending forced-flush cycle, stall-cycle count
  int m_wait = 0;
  bit m_tof  = 0;
  int m_cnt  = 0;

  pipeline_ctrl #(
    .NSTAGE  (5),
    .TIMEOUT (TO),
    .CNT_W   (3),
    .PERF_W  (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .flush_req    (flush_req),
    .stall        (stall),
    .bubble       (bubble),
    .flush        (flush),
    .bus_timeout  (bus_timeout),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout got=running want=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit id, input bit ex, input bit mem, input bit fl, input string tag);
    logic [4:0] es, eb;
    bit ef, et;
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    flush_req    = fl;
    #1;
    es = 5'b00000; eb = 5'b00000; ef = 0; et = 0;
    if (m_tof) begin
      eb = 5'b11110; ef = 1; et = 1;
    end else if (mem) begin
      es = 5'b01111; eb = 5'b10000;
    end else if (fl) begin
      eb = 5'b01110; ef = 1;
    end else if (ex) begin
      es = 5'b00111; eb = 5'b01000;
    end else if (id) begin
      es = 5'b00011; eb = 5'b00100;
    end
    chk({tag, ".stall"},   32'(stall),       32'(es));
    chk({tag, ".bubble"},  32'(bubble),      32'(eb));
    chk({tag, ".flush"},   32'(flush),       32'(ef));
    chk({tag, ".timeout"}, 32'(bus_timeout), 32'(et));
    chk({tag, ".cnt"},     32'(stall_cnt),   32'(m_cnt));
    @(posedge clk);
    if (es != 0 && m_cnt < PMAX) m_cnt++;
    if (m_tof) begin
      m_tof  = 0;
      m_wait = 0;
    end else if (mem) begin
      m_wait++;
      if (m_wait == TO) begin
        m_tof  = 1;
        m_wait = 0;
      end
    end else begin
      m_wait = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    bit id_r, ex_r, mem_r, fl_r;
    rst = 1'b0;
    stallreq_id = 1; stallreq_ex = 1; stallreq_mem = 1; flush_req = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.stall",   32'(stall),       32'h0);
    chk("rst.bubble",  32'(bubble),      32'h0);
    chk("rst.flush",   32'(flush),       32'h0);
    chk("rst.timeout", 32'(bus_timeout), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0, 0, "idle");
    step(1, 0, 0, 0, "id");
    step(0, 0, 0, 0, "id_after");
    step(1, 1, 1, 0, "prio_mem");
    step(1, 1, 0, 0, "prio_ex");
    step(0, 0, 0, 0, "prio_idle");
    step(0, 0, 0, 1, "flush");
    step(0, 0, 1, 1, "flush_lost");
    step(0, 0, 0, 0, "flush_idle");
    for (int i = 1; i <= TO + 1; i++) step(0, 0, 1, 0, $sformatf("wd%0d", i));
    step(0, 0, 0, 0, "wd_after");
    for (int i = 1; i < TO; i++) step(0, 0, 1, 0, $sformatf("wdrop%0d", i));
    step(0, 0, 0, 0, "wdrop_low");
    step(0, 0, 0, 0, "wdrop_idle");

    step(0, 0, 1, 0, "pre_rst1");
    step(0, 0, 1, 0, "pre_rst2");
    stallreq_mem = 1;
    #2 rst = 1'b0;
    #1;
    chk("arst.stall",   32'(stall),       32'h0);
    chk("arst.bubble",  32'(bubble),      32'h0);
    chk("arst.flush",   32'(flush),       32'h0);
    chk("arst.timeout", 32'(bus_timeout), 32'h0);
    chk("arst.cnt",     32'(stall_cnt),   32'h0);
    m_wait = 0; m_tof = 0; m_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= TO + 1; i++) step(0, 0, 1, 0, $sformatf("rwd%0d", i));
    step(0, 0, 0, 0, "rwd_after");

    mem_r = 0;
    for (int i = 0; i < 300; i++) begin
      if (mem_r) mem_r = ($urandom_range(7) != 0);
      else       mem_r = ($urandom_range(5) == 0);
      id_r = ($urandom_range(2) == 0);
      ex_r = ($urandom_range(2) == 0);
      fl_r = ($urandom_range(4) == 0);
      step(id_r, ex_r, mem_r, fl_r, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
